// File: rtl/hazard_flush_ctrl_if.sv
// Hazard/flush control bundle between the EX/ID hazard sources and the pipeline registers.
// The controller drives through modport master; the pipeline side uses modport slave.
interface hazard_flush_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             memreadE;
  logic [4:0]       rdE;
  logic [4:0]       rs1D;
  logic [4:0]       rs2D;
  logic             usesrs2D;
  logic             branchE;
  logic             takenE;
  logic             jumpE;
  logic [31:0]      targetE;
  logic             mem_busy;
  logic             stallF;
  logic             stallD;
  logic             stallE;
  logic             stallM;
  logic             flushD;
  logic             flushE;
  logic             pc_redirect;
  logic [31:0]      pc_target;
  logic             wait_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  memreadE, rdE, rs1D, rs2D, usesrs2D, branchE, takenE, jumpE, targetE, mem_busy,
    output stallF, stallD, stallE, stallM, flushD, flushE, pc_redirect, pc_target,
           wait_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    output memreadE, rdE, rs1D, rs2D, usesrs2D, branchE, takenE, jumpE, targetE, mem_busy,
    input  stallF, stallD, stallE, stallM, flushD, flushE, pc_redirect, pc_target,
           wait_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_flush_ctrl.sv
// Hazard/flush controller for the 5-stage pipeline: freeze > redirect > load-use bubble.
// Define HAZARD_PERF_EN to build the saturating stall/flush performance counters.
module hazard_flush_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_flush_ctrl_if.master  hz
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam logic [15:0] MAX_W = 16'(MAX_WAIT);

  state_t      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
  logic [15:0] wait_base;
  logic        redirect;
  logic        loaduse;
  logic        stall_f, stall_d, stall_e, stall_m;
  logic        flush_d, flush_e, redir;
  logic [31:0] target;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d = hz.mem_busy ? MEM_WAIT : RUN;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    redir   = 1'b0;
    target  = '0;

    redirect = (hz.branchE & hz.takenE) | hz.jumpE;
    loaduse  = hz.memreadE & (hz.rdE != 5'd0) &
               ((hz.rdE == hz.rs1D) | (hz.usesrs2D & (hz.rdE == hz.rs2D)));

    // Outputs are gated by reset so they fall with rst, not at the next edge.
    if (!rst) begin
      stall_f = 1'b0;
    end else if (hz.mem_busy) begin
      // The branch/jump simply waits in EX and redirects once memory is ready.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
    end else if (redirect) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      redir   = 1'b1;
      target  = hz.targetE;
    end else if (loaduse) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end

    // Leaving MEM_WAIT implies the run of busy cycles restarted from zero.
    wait_base = (state_q == MEM_WAIT) ? wait_cnt_q : 16'd0;
    if (hz.mem_busy) begin
      wait_cnt_d = (wait_base == MAX_W) ? wait_base : wait_base + 16'd1;
    end else begin
      wait_cnt_d = 16'd0;
    end
    timeout_d = timeout_q | (hz.mem_busy & (wait_base == MAX_W - 16'd1));
  end

  assign hz.stallF       = stall_f;
  assign hz.stallD       = stall_d;
  assign hz.stallE       = stall_e;
  assign hz.stallM       = stall_m;
  assign hz.flushD       = flush_d;
  assign hz.flushE       = flush_e;
  assign hz.pc_redirect  = redir;
  assign hz.pc_target    = target;
  assign hz.wait_timeout = timeout_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_f && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (redir && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = {CNT_W{1'b0}};
  assign hz.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Scoreboard bench for hazard_flush_ctrl (MAX_WAIT=4): directed vectors push expectations,
// a negedge monitor pops and compares against the live outputs.
module tb_hazard_flush_ctrl;

  localparam int CNT_W = 16;

  typedef struct packed {
    logic [6:0]  ctl;      // {stallF, stallD, stallE, stallM, flushD, flushE, pc_redirect}
    logic [31:0] target;
    logic        tmo;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  logic clk;
  logic rst;

  hazard_flush_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_flush_ctrl #(.MAX_WAIT(4), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.master)
  );

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] pc(input int v);
`ifdef HAZARD_PERF_EN
    return 16'(v);
`else
    return 16'(v & 0);
`endif
  endfunction

  // Monitor: combinational outputs are stable mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a.ctl    = {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushD, hz.flushE, hz.pc_redirect};
      a.target = hz.pc_target;
      a.tmo    = hz.wait_timeout;
      a.sc     = hz.stall_cnt;
      a.fc     = hz.flush_cnt;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: actual ctl=%b tgt=%h tmo=%b sc=%0d fc=%0d required ctl=%b tgt=%h tmo=%b sc=%0d fc=%0d",
                 n, a.ctl, a.target, a.tmo, a.sc, a.fc, e.ctl, e.target, e.tmo, e.sc, e.fc);
      end else begin
        $display("ok   %s: ctl=%b tgt=%h tmo=%b sc=%0d fc=%0d", n, a.ctl, a.target, a.tmo, a.sc, a.fc);
      end
    end
  end

  task automatic vec(input string n, input logic r, input logic mr, input logic [4:0] rd,
                     input logic [4:0] s1, input logic [4:0] s2, input logic us,
                     input logic br, input logic tk, input logic jp, input logic mb,
                     input logic [31:0] tg, input logic [6:0] ctl, input logic [31:0] etg,
                     input logic tmo, input int sc, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst         = r;
    hz.memreadE = mr;
    hz.rdE      = rd;
    hz.rs1D     = s1;
    hz.rs2D     = s2;
    hz.usesrs2D = us;
    hz.branchE  = br;
    hz.takenE   = tk;
    hz.jumpE    = jp;
    hz.mem_busy = mb;
    hz.targetE  = tg;
    e.ctl    = ctl;
    e.target = etg;
    e.tmo    = tmo;
    e.sc     = pc(sc);
    e.fc     = pc(fc);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  localparam logic [6:0] NONE  = 7'b0000000;
  localparam logic [6:0] LU    = 7'b1100010;
  localparam logic [6:0] RDIR  = 7'b0000111;
  localparam logic [6:0] FRZ   = 7'b1111000;

  initial begin
    rst = 1'b0;
    hz.memreadE = 0; hz.rdE = 0; hz.rs1D = 0; hz.rs2D = 0; hz.usesrs2D = 0;
    hz.branchE = 0; hz.takenE = 0; hz.jumpE = 0; hz.mem_busy = 0; hz.targetE = 0;

    //  name            rst mr rd  rs1 rs2 us br tk jp mb target        ctl   etarget       tmo sc  fc
    vec("reset_gate",   0, 0, 0,  0,  0,  0, 0, 0, 1, 0, 32'h40,      NONE, 32'h0,        0,  0,  0);
    vec("idle",         1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 32'h0,       NONE, 32'h0,        0,  0,  0);
    vec("lu_rs1",       1, 1, 5,  5,  0,  0, 0, 0, 0, 0, 32'h0,       LU,   32'h0,        0,  0,  0);
    vec("lu_bubble",    1, 0, 5,  5,  0,  0, 0, 0, 0, 0, 32'h0,       NONE, 32'h0,        0,  1,  0);
    vec("lu_rd0",       1, 1, 0,  0,  0,  0, 0, 0, 0, 0, 32'h0,       NONE, 32'h0,        0,  1,  0);
    vec("lu_rs2_unused",1, 1, 7,  3,  7,  0, 0, 0, 0, 0, 32'h0,       NONE, 32'h0,        0,  1,  0);
    vec("lu_rs2_used",  1, 1, 7,  3,  7,  1, 0, 0, 0, 0, 32'h0,       LU,   32'h0,        0,  1,  0);
    vec("br_taken",     1, 0, 0,  0,  0,  0, 1, 1, 0, 0, 32'h40,      RDIR, 32'h40,       0,  2,  0);
    vec("br_not_taken", 1, 0, 0,  0,  0,  0, 1, 0, 0, 0, 32'h80,      NONE, 32'h0,        0,  2,  1);
    vec("frz_jump_1",   1, 0, 0,  0,  0,  0, 0, 0, 1, 1, 32'h100,     FRZ,  32'h0,        0,  2,  1);
    vec("frz_jump_2",   1, 0, 0,  0,  0,  0, 0, 0, 1, 1, 32'h100,     FRZ,  32'h0,        0,  3,  1);
    vec("frz_jump_3",   1, 0, 0,  0,  0,  0, 0, 0, 1, 1, 32'h100,     FRZ,  32'h0,        0,  4,  1);
    vec("jump_release", 1, 0, 0,  0,  0,  0, 0, 0, 1, 0, 32'h100,     RDIR, 32'h100,      0,  5,  1);
    vec("idle2",        1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 32'h0,       NONE, 32'h0,        0,  5,  2);
    vec("rdir_over_lu", 1, 1, 5,  5,  0,  0, 0, 0, 1, 0, 32'h200,     RDIR, 32'h200,      0,  5,  2);
    vec("idle3",        1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 32'h0,       NONE, 32'h0,        0,  5,  3);
    vec("busy_1",       1, 0, 0,  0,  0,  0, 0, 0, 0, 1, 32'h0,       FRZ,  32'h0,        0,  5,  3);
    vec("busy_2",       1, 0, 0,  0,  0,  0, 0, 0, 0, 1, 32'h0,       FRZ,  32'h0,        0,  6,  3);
    vec("busy_3",       1, 0, 0,  0,  0,  0, 0, 0, 0, 1, 32'h0,       FRZ,  32'h0,        0,  7,  3);
    vec("busy_4_pre",   1, 0, 0,  0,  0,  0, 0, 0, 0, 1, 32'h0,       FRZ,  32'h0,        0,  8,  3);
    vec("busy_5_tmo",   1, 0, 0,  0,  0,  0, 0, 0, 0, 1, 32'h0,       FRZ,  32'h0,        1,  9,  3);
    vec("tmo_sticky_1", 1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 32'h0,       NONE, 32'h0,        1, 10,  3);
    vec("tmo_sticky_2", 1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 32'h0,       NONE, 32'h0,        1, 10,  3);
    vec("pre_rst_frz",  1, 0, 0,  0,  0,  0, 0, 0, 0, 1, 32'h0,       FRZ,  32'h0,        1, 10,  3);
    vec("rst_mid_frz",  0, 0, 0,  0,  0,  0, 0, 0, 0, 1, 32'h0,       NONE, 32'h0,        0,  0,  0);
    vec("post_rst_lu",  1, 1, 9,  0,  9,  1, 0, 0, 0, 0, 32'h0,       LU,   32'h0,        0,  0,  0);
    vec("pre_rst_rdir", 1, 0, 0,  0,  0,  0, 0, 0, 1, 0, 32'h300,     RDIR, 32'h300,      0,  1,  0);
    vec("rst_mid_rdir", 0, 0, 0,  0,  0,  0, 0, 0, 1, 0, 32'h300,     NONE, 32'h0,        0,  0,  0);
    vec("post_rst_idle",1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 32'h0,       NONE, 32'h0,        0,  0,  0);
    vec("rbusy_1",      1, 0, 0,  0,  0,  0, 0, 0, 0, 1, 32'h0,       FRZ,  32'h0,        0,  0,  0);
    vec("rbusy_2",      1, 0, 0,  0,  0,  0, 0, 0, 0, 1, 32'h0,       FRZ,  32'h0,        0,  1,  0);
    vec("rbusy_3",      1, 0, 0,  0,  0,  0, 0, 0, 0, 1, 32'h0,       FRZ,  32'h0,        0,  2,  0);
    vec("rbusy_idle",   1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 32'h0,       NONE, 32'h0,        0,  3,  0);
    vec("lu_br_nt",     1, 1, 4,  4,  0,  0, 1, 0, 0, 0, 32'h44,      LU,   32'h0,        0,  3,  0);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual pending=%0d required pending=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_flush_ctrl.md
Name: hazard_flush_ctrl

Overview:
- Hazard and flush controller for the 5-stage MIPS pipeline.
- Producer side of the ID/EX flush interface: generates flush/stall that clear or hold pipeline registers, plus the PC redirect.
- Detects load-use hazards (1-cycle bubble), taken branches/jumps resolved in EX (flush IF/ID and ID/EX), and data-memory wait (whole-pipeline freeze with timeout).
- Keeps saturating stall/flush performance counters.

Parameters:
- MAX_WAIT, 16: consecutive mem_busy cycles before wait_timeout sets; legal range 2..65535.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- memreadE  in  1  instruction in EX is a load.
- rdE  in  5  destination register of the instruction in EX.
- rs1D, rs2D  in  5  source registers of the instruction in ID.
- usesrs2D  in  1  instruction in ID reads rs2 (0 for immediate forms).
- branchE  in  1  EX holds a branch.
- takenE  in  1  branch condition true.
- jumpE  in  1  EX holds a jump.
- targetE  in  32  resolved branch/jump target.
- mem_busy  in  1  data memory not ready this cycle.
- stallF, stallD  out  1  hold PC and IF/ID.
- stallE, stallM  out  1  hold ID/EX and EX/MEM.
- flushD  out  1  clear IF/ID.
- flushE  out  1  clear ID/EX; drives the ID/EX flush input.
- pc_redirect  out  1  load targetE into the PC.
- pc_target  out  32  redirect address.
- wait_timeout  out  1  sticky memory-wait error.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN; wait_cnt, wait_timeout, stall_cnt and flush_cnt = 0.
  - All combinational outputs are forced to 0, including pc_target.
- States RUN and MEM_WAIT:
  - Next state is MEM_WAIT if mem_busy=1 at the clock edge, otherwise RUN.
  - The state affects only wait_cnt and wait_timeout. Stall and flush outputs are combinational, same-cycle, zero latency.
- Event definitions:
  - redirect = (branchE & takenE) | jumpE.
  - loaduse = memreadE & (rdE!=0) & ((rdE==rs1D) | (usesrs2D & (rdE==rs2D))).
- Priority, highest first:
  1. Freeze: mem_busy=1 → stallF=stallD=stallE=stallM=1; flushD=flushE=pc_redirect=0. The branch stays in EX and redirects in the first cycle with mem_busy=0. No latching of redirect is needed.
  2. Redirect: flushD=flushE=pc_redirect=1; pc_target=targetE; no stalls.
  3. Load-use: stallF=stallD=1 and flushE=1 (bubble into EX); stallE=stallM=0.
  4. Otherwise all outputs are 0.
- pc_target = targetE only while pc_redirect=1; 0 otherwise.
- Load-use stall lasts exactly 1 cycle: the next cycle has a bubble in EX with memreadE=0.
- A load in EX with rdE=0 never stalls.
- wait_cnt (16 b):
  - Increments at each edge with mem_busy=1.
  - Clears at each edge with mem_busy=0.
  - Saturates at MAX_WAIT.
- wait_timeout:
  - Sets at the edge where mem_busy=1 and wait_cnt==MAX_WAIT-1, i.e. after MAX_WAIT consecutive busy edges.
  - Sticky until reset; it does not alter pipeline control.
- stall_cnt: +1 at each edge where stallF=1 (freeze or load-use). flush_cnt: +1 at each edge where pc_redirect=1. Both saturate at all-ones.
- Reset mid-freeze: outputs drop immediately (asynchronous); after release, operation restarts in RUN with wait_cnt=0.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: stall_cnt and flush_cnt operate as above.
- Undefined: counter logic is not compiled; stall_cnt and flush_cnt are tied to 0; ports remain present.

Test Plan:
- Load-use: memreadE=1, rdE=5, rs1D=5 → stallF=stallD=flushE=1 for one cycle; flushD=0; next cycle (memreadE=0) all 0; stall_cnt=1.
- memreadE=1, rdE=0, rs1D=0; then rdE=7, rs2D=7, usesrs2D=0 → no stall or flush in either case.
- branchE=1, takenE=1, targetE=0x00000040 → flushD=flushE=pc_redirect=1, pc_target=0x40 the same cycle; flush_cnt=1. Repeat with takenE=0 → no flush.
- jumpE=1 with mem_busy=1 for 3 cycles → freeze stalls=1 and no flush for 3 cycles; in cycle 4, pc_redirect=1; stall_cnt=3, flush_cnt=1.
- MAX_WAIT=4, mem_busy held 5 cycles → wait_timeout=0 after 3 edges, 1 after the 4th edge; stays 1 after mem_busy drops.
- rst pulsed low mid-freeze and mid-redirect → all outputs and counters 0 asynchronously; wait_timeout cleared; normal detection resumes after release.
